// File: rtl/bin_add_const_pipe.sv
// Multi-lane carry + operand + mode-selected constant adder with stall, configurable
// output delay, per-lane overflow detection and a sticky overflow flag.
module bin_add_const_pipe #(
    parameter int unsigned OP_WIDTH    = 16,
    parameter int unsigned CARRY_WIDTH = 1,
    parameter int unsigned SUM_WIDTH   = 17,
    parameter int unsigned LANES       = 4,
    parameter int unsigned DELAY       = 1,
    parameter int unsigned CONST_A     = 0,
    parameter int unsigned CONST_B     = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic                                hold,
    input  logic [1:0]                          const_sel,
    input  logic [LANES*CARRY_WIDTH-1:0]        in_a,
    input  logic [LANES*OP_WIDTH-1:0]           in_b,
    input  logic                                clr_ovf,
    output logic                                out_valid,
    output logic [LANES*OP_WIDTH-1:0]           low_sum,
    output logic [LANES*(SUM_WIDTH-OP_WIDTH)-1:0] hi_sum,
    output logic [LANES-1:0]                    lane_ovf,
    output logic                                ovf_sticky
);

    localparam int unsigned HI_WIDTH   = SUM_WIDTH - OP_WIDTH;
    localparam int unsigned FULL_WIDTH = (SUM_WIDTH > OP_WIDTH + 2) ? SUM_WIDTH : OP_WIDTH + 2;
    localparam logic [OP_WIDTH:0] K_A  = (OP_WIDTH + 1)'(CONST_A);
    localparam logic [OP_WIDTH:0] K_B  = (OP_WIDTH + 1)'(CONST_B);

    // Stage 1: input latch with the constant decoded one bit wider than an operand
    logic [OP_WIDTH:0]               const_dec;
    logic                            s1_valid;
    logic [LANES*CARRY_WIDTH-1:0]    s1_a;
    logic [LANES*OP_WIDTH-1:0]       s1_b;
    logic [OP_WIDTH:0]               s1_const;

    always_comb begin
        const_dec = '0;
        case (const_sel)
            2'd1:    const_dec = K_A;
            2'd2:    const_dec = K_B;
            2'd3:    const_dec = K_A + K_B;
            default: const_dec = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_const <= '0;
        end else if (!hold) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_const <= const_dec;
        end
    end

    // Stage 2 adder; overflow is any result bit at or above SUM_WIDTH
    logic [LANES*SUM_WIDTH-1:0] add_sum;
    logic [LANES-1:0]           add_ovf;

    always_comb begin
        logic [FULL_WIDTH-1:0] full;
        full    = '0;
        add_sum = '0;
        add_ovf = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            full = FULL_WIDTH'(s1_a[l*CARRY_WIDTH +: CARRY_WIDTH])
                 + FULL_WIDTH'(s1_b[l*OP_WIDTH +: OP_WIDTH])
                 + FULL_WIDTH'(s1_const);
            add_sum[l*SUM_WIDTH +: SUM_WIDTH] = full[SUM_WIDTH-1:0];
            add_ovf[l] = (full >> SUM_WIDTH) != '0;
        end
    end

    // Entry 0 is the adder register, entries 1..DELAY are the pure delay stages
    logic [LANES*SUM_WIDTH-1:0] pipe_sum [DELAY+1];
    logic [LANES-1:0]           pipe_ovf [DELAY+1];
    logic [DELAY:0]             pipe_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int unsigned i = 0; i <= DELAY; i++) begin
                pipe_sum[i] <= '0;
                pipe_ovf[i] <= '0;
            end
        end else if (!hold) begin
            pipe_valid[0] <= s1_valid;
            pipe_sum[0]   <= add_sum;
            pipe_ovf[0]   <= add_ovf;
            for (int unsigned i = 1; i <= DELAY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_sum[i]   <= pipe_sum[i-1];
                pipe_ovf[i]   <= pipe_ovf[i-1];
            end
        end
    end

    assign out_valid = pipe_valid[DELAY];
    assign lane_ovf  = pipe_ovf[DELAY];

    always_comb begin
        low_sum = '0;
        hi_sum  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            low_sum[l*OP_WIDTH +: OP_WIDTH] = pipe_sum[DELAY][l*SUM_WIDTH +: OP_WIDTH];
            hi_sum[l*HI_WIDTH +: HI_WIDTH]  = pipe_sum[DELAY][l*SUM_WIDTH + OP_WIDTH +: HI_WIDTH];
        end
    end

    // A beat only counts toward the sticky flag when it is consumed (not held); set beats clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && !hold && (lane_ovf != '0)) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin_add_const_pipe.sv
// Scoreboard bench for bin_add_const_pipe: directed scenarios plus randomized traffic,
// checked against an arithmetic reference model with non-held-cycle latency tracking.
module tb_bin_add_const_pipe;

    localparam int unsigned OP  = 16;
    localparam int unsigned CW  = 1;
    localparam int unsigned SW  = 17;
    localparam int unsigned LN  = 4;
    localparam int unsigned DL  = 1;
    localparam int unsigned HW  = SW - OP;
    localparam int unsigned LAT = 2 + DL;
    localparam longint unsigned CA = 64'h1234;
    localparam longint unsigned CB = 64'hFFFF;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  hold;
    logic [1:0]            const_sel;
    logic [LN*CW-1:0]      in_a;
    logic [LN*OP-1:0]      in_b;
    logic                  clr_ovf;
    logic                  out_valid;
    logic [LN*OP-1:0]      low_sum;
    logic [LN*HW-1:0]      hi_sum;
    logic [LN-1:0]         lane_ovf;
    logic                  ovf_sticky;

    bin_add_const_pipe #(
        .OP_WIDTH(OP), .CARRY_WIDTH(CW), .SUM_WIDTH(SW), .LANES(LN), .DELAY(DL),
        .CONST_A(32'h1234), .CONST_B(32'hFFFF)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .hold(hold), .const_sel(const_sel),
        .in_a(in_a), .in_b(in_b), .clr_ovf(clr_ovf), .out_valid(out_valid),
        .low_sum(low_sum), .hi_sum(hi_sum), .lane_ovf(lane_ovf), .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned      t;
        logic [LN*OP-1:0] low;
        logic [LN*HW-1:0] hi;
        logic [LN-1:0]    ovf;
    } exp_t;

    exp_t        q[$];
    int unsigned adv = 0;
    int          checks = 0;
    int          errors = 0;
    bit          started = 0;
    bit          sticky_m = 0;
    bit          exp_valid;

    // Count of clock edges at which the pipeline advanced
    always @(posedge clk) if (!reset && !hold) adv <= adv + 1;

    function automatic exp_t predict(input logic [1:0] s, input logic [LN*CW-1:0] a,
                                     input logic [LN*OP-1:0] b, input int unsigned t);
        exp_t e;
        longint unsigned k, full, sum;
        e.t = t; e.low = '0; e.hi = '0; e.ovf = '0;
        case (s)
            2'd0:    k = 0;
            2'd1:    k = CA;
            2'd2:    k = CB;
            default: k = CA + CB;
        endcase
        for (int l = 0; l < int'(LN); l++) begin
            full = 64'(a[l*CW +: CW]) + 64'(b[l*OP +: OP]) + k;
            sum  = full % (64'd1 << SW);
            e.ovf[l] = full >= (64'd1 << SW);
            e.low[l*OP +: OP] = OP'(sum % (64'd1 << OP));
            e.hi[l*HW +: HW]  = HW'(sum >> OP);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            exp_valid = (q.size() > 0) && (q[0].t + LAT == adv);
            checks++;
            if (out_valid !== exp_valid) begin
                errors++;
                $display("FAIL out_valid t=%0t actual=%b expected=%b", $time, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (low_sum !== q[0].low) begin
                    errors++;
                    $display("FAIL low_sum t=%0t actual=%h expected=%h", $time, low_sum, q[0].low);
                end
                checks++;
                if (hi_sum !== q[0].hi) begin
                    errors++;
                    $display("FAIL hi_sum t=%0t actual=%b expected=%b", $time, hi_sum, q[0].hi);
                end
                checks++;
                if (lane_ovf !== q[0].ovf) begin
                    errors++;
                    $display("FAIL lane_ovf t=%0t actual=%b expected=%b", $time, lane_ovf, q[0].ovf);
                end
            end
            checks++;
            if (ovf_sticky !== sticky_m) begin
                errors++;
                $display("FAIL ovf_sticky t=%0t actual=%b expected=%b", $time, ovf_sticky, sticky_m);
            end
            if (reset) begin
                q.delete();
                sticky_m = 0;
            end else begin
                if (exp_valid && !hold && q[0].ovf != '0) sticky_m = 1;
                else if (clr_ovf) sticky_m = 0;
                if (exp_valid && !hold) void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic h, input logic [1:0] s,
                         input logic [LN*CW-1:0] a, input logic [LN*OP-1:0] b, input logic c);
        @(posedge clk); #1;
        in_valid = v; hold = h; const_sel = s; in_a = a; in_b = b; clr_ovf = c;
        if (v && !h && !reset) q.push_back(predict(s, a, b, adv));
    endtask

    task automatic idle(input int n, input logic c);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, '0, '0, c);
    endtask

    task automatic rand_inputs();
        in_valid  = 1'($urandom);
        const_sel = 2'($urandom);
        in_a      = (LN*CW)'($urandom);
        in_b      = (LN*OP)'({$urandom(), $urandom()});
        clr_ovf   = 1'($urandom);
        hold      = 1'b1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        rand_inputs();
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || lane_ovf !== '0 || ovf_sticky !== 1'b0 ||
                low_sum !== '0 || hi_sum !== '0) begin
                errors++;
                $display("FAIL reset_state t=%0t actual v=%b ovf=%b st=%b low=%h hi=%b expected all zero",
                         $time, out_valid, lane_ovf, ovf_sticky, low_sum, hi_sum);
            end
            started = 1;
            if (i < n) begin
                rand_inputs();
            end else begin
                reset = 1'b0; in_valid = 1'b0; hold = 1'b0; clr_ovf = 1'b0;
                const_sel = '0; in_a = '0; in_b = '0;
            end
        end
    endtask

    logic [LN*OP-1:0] b_all_ffff;
    logic [LN*OP-1:0] rb;

    initial begin
        reset = 1'b1; in_valid = 1'b0; hold = 1'b1; const_sel = '0;
        in_a = '0; in_b = '0; clr_ovf = 1'b0;
        b_all_ffff = '1;

        do_reset(3);

        // lane0: 1 + 0xFFFF + 0x1234 = 0x11234
        drive(1'b1, 1'b0, 2'd1, (LN*CW)'(1), (LN*OP)'(16'hFFFF), 1'b0);
        idle(LAT + 2, 1'b0);

        // mode 3 on all lanes overflows: 1 + 0xFFFF + 0x11233
        drive(1'b1, 1'b0, 2'd3, '1, b_all_ffff, 1'b0);
        idle(LAT + 2, 1'b0);

        // clear held every cycle while an overflowing beat emerges
        drive(1'b1, 1'b0, 2'd3, '1, b_all_ffff, 1'b1);
        idle(LAT + 3, 1'b1);
        idle(2, 1'b0);

        // stall mid-stream
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                drive(1'b1, 1'b1, 2'd2, '1, '1, 1'b0);
                drive(1'b1, 1'b1, 2'd2, '1, '1, 1'b0);
            end
            rb = '0;
            for (int l = 0; l < int'(LN); l++) rb[l*OP +: OP] = OP'(i);
            drive(1'b1, 1'b0, 2'd1, (LN*CW)'(i), rb, 1'b0);
        end
        idle(LAT + 3, 1'b0);

        // hold while a beat is presented
        drive(1'b1, 1'b0, 2'd3, '1, b_all_ffff, 1'b0);
        for (int i = 0; i < LAT + 3; i++) drive(1'b0, (i >= LAT - 1 && i < LAT + 1), 2'd0, '0, '0, 1'b0);
        idle(2, 1'b1);

        // alternating const_sel back-to-back
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b0, 2'(i), (LN*CW)'($urandom), (LN*OP)'({$urandom(), $urandom()}), 1'b0);
        idle(LAT + 2, 1'b0);

        // reset with five beats in flight
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b0, 2'(i), (LN*CW)'($urandom), (LN*OP)'({$urandom(), $urandom()}), 1'b0);
        do_reset(1);
        drive(1'b1, 1'b0, 2'd2, '1, (LN*OP)'({$urandom(), $urandom()}), 1'b0);
        idle(LAT + 3, 1'b0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                rb = (LN*OP)'({$urandom(), $urandom()});
                if ($urandom_range(0, 1) == 1) rb = rb | {LN{16'hF000}};
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 2'($urandom),
                      (LN*CW)'($urandom), rb, $urandom_range(0, 9) == 0);
            end
        end
        idle(LAT + 6, 1'b0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending beats expected=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_add_const_pipe.md
# bin_add_const_pipe

Multi-lane, valid-qualified successor to the single-lane 3-input constant adder used in the reverse converter. Each of LANES lanes adds a carry operand, a binary operand and a mode-selected constant through a pipeline of configurable depth. A stall input freezes the whole pipeline. Per-lane overflow detection and a sticky overflow flag are included. It sits between the mixed-radix digit stages and the binary output assembly of the reverse converter.

## Interface
- OP_WIDTH, 16: width of binary operand and of `low_sum` per lane
- CARRY_WIDTH, 1: width of carry operand per lane; must be ≤ OP_WIDTH
- SUM_WIDTH, 17: total sum width per lane; must be > OP_WIDTH
- LANES, 4: number of independent adder lanes; ≥ 1
- DELAY, 1: extra output pipeline stages after the adder; ≥ 0
- CONST_A, 0: constant A; must fit in OP_WIDTH bits
- CONST_B, 0: constant B; must fit in OP_WIDTH bits

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- hold  in  1  stall; when high, every pipeline register keeps its value
- const_sel  in  2  constant mode for this beat: 0→0, 1→CONST_A, 2→CONST_B, 3→CONST_A+CONST_B
- in_a  in  LANES*CARRY_WIDTH  carry operands; lane i at [i*CARRY_WIDTH +: CARRY_WIDTH]
- in_b  in  LANES*OP_WIDTH  binary operands; lane i at [i*OP_WIDTH +: OP_WIDTH]
- clr_ovf  in  1  clears `ovf_sticky`
- out_valid  out  1  output beat valid
- low_sum  out  LANES*OP_WIDTH  sum bits [OP_WIDTH-1:0] per lane
- hi_sum  out  LANES*(SUM_WIDTH-OP_WIDTH)  sum bits [SUM_WIDTH-1:OP_WIDTH] per lane
- lane_ovf  out  LANES  per-lane overflow, aligned with out_valid
- ovf_sticky  out  1  OR of every lane_ovf reported with out_valid since the last clear

## Operation
- Stage 1 (input latch): register in_a, in_b, in_valid and the decoded constant. The decoded constant is computed at OP_WIDTH+1 bits so that mode 3 cannot truncate.
- Stage 2 (add): per lane, full = carry + b + const, computed at OP_WIDTH+2 bits, zero-extended.
  - Register full[SUM_WIDTH-1:0] as the sum.
  - Register lane_ovf = 1 if any bit of full at or above SUM_WIDTH is nonzero. If SUM_WIDTH ≥ OP_WIDTH+2, lane_ovf is constant 0.
- Stages 3..2+DELAY: pure delay registers for sum, lane_ovf and valid.
- Data registers load every non-held cycle, whatever the valid state. Consumers qualify outputs with out_valid only.
- hold=1 freezes all stages, including valid bits. Inputs presented during hold are ignored, not queued.
- ovf_sticky is set when out_valid=1, hold=0 and any lane_ovf=1. It is cleared by clr_ovf or reset.
  - If clr_ovf and a set condition occur in the same cycle, the set wins.
- There is no state machine beyond the valid shift chain. A beat cannot be dropped or duplicated except by reset.

## Timing
- Latency: 2+DELAY cycles from in_valid sampled high (hold=0) to out_valid high, not counting held cycles. Each held cycle adds exactly one cycle.
- Throughput: one beat per non-held cycle.
- Reset (synchronous, dominates hold and all other inputs):
  - All valid bits, out_valid, lane_ovf and ovf_sticky go to 0.
  - All data registers go to 0, so low_sum=0 and hi_sum=0.
  - These values are visible the cycle after reset is sampled high.
- Reset mid-stream: every in-flight beat is discarded. The first beat accepted after reset deasserts emerges after the full latency.
- Back-to-back beats with alternating const_sel: each beat uses the const_sel sampled with it, with no cross-beat leakage.
- hold asserted while out_valid=1: outputs hold steady and the beat stays presented. ovf_sticky does not re-set during hold.

## Test plan
- Reset then idle: assert reset 3 cycles with random inputs and hold=1 → out_valid, lane_ovf, ovf_sticky, low_sum and hi_sum are all 0 from the cycle after the first reset sample.
- Basic add, DELAY=1, LANES=4, CONST_A=0x1234:
  - Stimulus: lane0 a=1, b=0xFFFF, const_sel=1.
  - Response: out_valid exactly 3 cycles later; lane0 low_sum=0x1234, hi_sum=1; lane_ovf=0.
- Mode 3 overflow, SUM_WIDTH=17, CONST_A=CONST_B=0xFFFF:
  - Stimulus: b=0xFFFF, a=1.
  - Response: full=0x2FFFE; sum=0x0FFFE (low 0xFFFE, hi 0); lane_ovf=1; ovf_sticky=1 the next cycle.
- Stall: stream 8 beats with b=0..7 and hold pulsed 2 cycles mid-stream → exactly 8 outputs in order, b+const, latency extended by 2, no duplicates.
- Sticky clear race: clr_ovf asserted in the same cycle as an overflowing output beat → ovf_sticky remains 1. A clr_ovf on a later clean cycle → 0.
- Reset mid-stream: 5 beats in flight, reset for 1 cycle → no out_valid for any pre-reset beat. A new beat accepted afterwards appears after 2+DELAY cycles.
